fb_prog_loader: RTL and testbench
=================================

Name: fb_prog_loader

Overview:
Program loader and RAM-port mux sitting directly upstream of the block RAM and the fb_cpu core. It accepts a length-prefixed stream of 10-bit words over a valid/ready handshake, writes them sequentially into RAM from address 0, and holds the CPU in reset while loading. Once loading completes it releases the CPU and passes the CPU's RAM port (MAR/MDRIn/RAMWr) through to the RAM.

Parameters:
ADDRESS_WIDTH, 6, RAM address width.
DATA_WIDTH, 10, RAM/instruction word width.
DEPTH, 64, RAM words; legal program length range is 1..DEPTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
i_valid  input  1  stream word valid.
i_data  input  DATA_WIDTH  stream word (header or program word).
o_ready  output  1  loader can accept a word this cycle.
i_start  input  1  single-cycle pulse; in RUN or ERR, re-enters loading.
cpu_addr  input  ADDRESS_WIDTH  CPU MAR.
cpu_wdata  input  DATA_WIDTH  CPU MDRIn.
cpu_we  input  1  CPU RAMWr.
ram_addr  output  ADDRESS_WIDTH  to RAM i_addr.
ram_wdata  output  DATA_WIDTH  to RAM i_ram_data_in.
ram_we  output  1  to RAM i_we.
cpu_rst  output  1  active-high reset to fb_cpu.
o_done  output  1  high while in RUN.
o_err  output  1  sticky error flag; cleared by i_start or reset.

Behaviour:
- Reset (rst=0, async): state=HDR, wr_ptr=0, len=0, cpu_rst=1, o_done=0, o_err=0.
- States: HDR (await length word), LOAD (await program words), RUN (CPU owns RAM), ERR (halted).
- Handshake: a word transfers on a rising edge where i_valid && o_ready. o_ready=1 in HDR and LOAD only. i_data is sampled only on transfer; i_valid gaps of any length are allowed.
- HDR: on transfer, if i_data==0 or i_data>DEPTH, go to ERR and set o_err. Otherwise len=i_data[ADDRESS_WIDTH:0], wr_ptr=0, go to LOAD.
- LOAD: ram_we = i_valid (o_ready=1), ram_addr=wr_ptr, ram_wdata=i_data. These are combinational, so the write occurs on the same edge as the transfer. wr_ptr increments per transfer. On the transfer with wr_ptr==len-1, go to RUN. wr_ptr never wraps: len<=DEPTH guarantees this.
- RUN: ram_addr/ram_wdata/ram_we = cpu_addr/cpu_wdata/cpu_we (combinational pass-through). o_done=1.
- Outside RUN: ram_we=0 except during a LOAD transfer. ram_addr/ram_wdata=0 when idle. CPU port inputs are ignored.
- cpu_rst is registered: 1 in HDR/LOAD/ERR, and 0 from the first cycle state==RUN. The CPU therefore starts its fetch from PC=0 one cycle after the last word is written.
- i_start in RUN or ERR: next state HDR, o_err cleared, cpu_rst reasserted the same edge. i_start in HDR/LOAD is ignored.
- i_valid and i_start in the same cycle in RUN: i_start wins. o_ready is 0 in RUN, so no word is consumed.
- Reset mid-LOAD: immediate return to HDR. Already-written RAM words are not cleared.
- Total RTL scope: FSM + pointer/length counters + port mux, roughly 150-250 lines.

Optional Feature:
LOADER_CSUM_EN:
- Defined: after the len program words, one extra checksum word is expected (state CSUM, o_ready=1, no RAM write). Checksum is the modulo-2^DATA_WIDTH sum of the program words only. On match go to RUN; on mismatch go to ERR, set o_err, and keep cpu_rst=1.
- Undefined: no CSUM state; LOAD goes straight to RUN after the last word.

Test Plan:
1. Stream 0x004, 0x032, 0x0B3, 0x074, 0x240 with i_valid held high → RAM[0..3]=0x032,0x0B3,0x074,0x240. cpu_rst falls on the cycle after the 0x240 transfer, o_done=1. Also preload RAM[50]=5, RAM[51]=10 → after the CPU halts, RAM[52]=15.
2. Same stream as scenario 1, with i_valid deasserted for 3 cycles between every word → identical RAM contents. cpu_rst remains 1 throughout the gaps. No extra ram_we pulses.
3. Header 0x000, then separately header 0x041 (65) → ERR, o_err=1, o_ready=0, cpu_rst=1. Pulse i_start → state HDR, o_err=0.
4. In RUN, drive cpu_addr=52, cpu_wdata=0x00F, cpu_we=1 → ram_addr=52, ram_wdata=0x00F, ram_we=1 in the same cycle. Pulse i_start → cpu_rst=1 on the next edge, ram_we=0.
5. Assert rst low after 2 of 4 program words → all outputs return to reset values asynchronously. Reload with a full stream → completes normally.
6. (LOADER_CSUM_EN) Stream 0x002, 0x005, 0x00A, 0x00F → RUN. Stream 0x002, 0x005, 0x00A, 0x010 → ERR, o_err=1, cpu_rst=1.

Source files
------------

// File: rtl/fb_prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : fb_prog_loader_if
//  Purpose  : Length-prefixed program stream (valid/ready handshake) feeding
//             the fb_prog_loader.
//  Revision : 1.0  initial release
// ============================================================================
interface fb_prog_loader_if #(
   parameter int DATA_WIDTH = 10
);
   logic                  i_valid;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  o_ready;

   // Stream source drives valid/data and observes ready.
   modport master (output i_valid, output i_data, input o_ready);
   // Loader consumes the stream.
   modport slave  (input i_valid, input i_data, output o_ready);
endinterface
`default_nettype wire

// File: rtl/fb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : fb_prog_loader
//  Purpose  : Loads a length-prefixed program stream into block RAM from
//             address 0 while holding fb_cpu in reset, then releases the CPU
//             and passes its RAM port (MAR/MDRIn/RAMWr) through to the RAM.
//  Option   : LOADER_CSUM_EN - expect a trailing checksum word (mod 2^DW sum
//             of the program words); a mismatch halts in ERR.
//  Revision : 1.0  initial release
// ============================================================================
module fb_prog_loader #(
   parameter int ADDRESS_WIDTH = 6,
   parameter int DATA_WIDTH    = 10,
   parameter int DEPTH         = 64
) (
   input  wire logic                     clk,
   input  wire logic                     rst,
   fb_prog_loader_if.slave               strm,
   input  wire logic                     i_start,
   input  wire logic [ADDRESS_WIDTH-1:0] cpu_addr,
   input  wire logic [DATA_WIDTH-1:0]    cpu_wdata,
   input  wire logic                     cpu_we,
   output logic      [ADDRESS_WIDTH-1:0] ram_addr,
   output logic      [DATA_WIDTH-1:0]    ram_wdata,
   output logic                          ram_we,
   output logic                          cpu_rst,
   output logic                          o_done,
   output logic                          o_err
);

`ifdef LOADER_CSUM_EN
   typedef enum logic [2:0] {HDR = 3'd0, LOAD = 3'd1, RUN = 3'd2, ERR = 3'd3, CSUM = 3'd4} state_t;
`else
   typedef enum logic [2:0] {HDR = 3'd0, LOAD = 3'd1, RUN = 3'd2, ERR = 3'd3} state_t;
`endif

   localparam logic [ADDRESS_WIDTH:0]  LEN_ONE   = 1;
   localparam logic [DATA_WIDTH-1:0]   DEPTH_MAX = DATA_WIDTH'(DEPTH);

   state_t                   state;
   state_t                   state_nxt;
   logic [ADDRESS_WIDTH-1:0] wr_ptr;
   logic [ADDRESS_WIDTH:0]   len;
   logic                     ready;
   logic                     xfer;
   logic                     hdr_bad;
   logic                     last_word;

   // Ready only while the loader is consuming the stream.
   always_comb begin
      ready = (state == HDR) || (state == LOAD);
`ifdef LOADER_CSUM_EN
      if (state == CSUM) ready = 1'b1;
`endif
   end

   assign strm.o_ready = ready;
   assign xfer         = strm.i_valid && ready;
   assign hdr_bad      = (strm.i_data == '0) || (strm.i_data > DEPTH_MAX);
   assign last_word    = ({1'b0, wr_ptr} == (len - LEN_ONE));
   assign o_done       = (state == RUN);

`ifdef LOADER_CSUM_EN
   logic [DATA_WIDTH-1:0] csum;

   // Running sum of program words; restarted by each accepted header.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         csum <= '0;
      end else if (xfer && state == HDR) begin
         csum <= '0;
      end else if (xfer && state == LOAD) begin
         csum <= csum + strm.i_data;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= HDR;
      else      state <= state_nxt;
   end

   // Next-state logic; i_start is only honoured once loading is over.
   always_comb begin
      state_nxt = state;
      case (state)
         HDR: begin
            if (xfer) state_nxt = hdr_bad ? ERR : LOAD;
         end
         LOAD: begin
`ifdef LOADER_CSUM_EN
            if (xfer && last_word) state_nxt = CSUM;
`else
            if (xfer && last_word) state_nxt = RUN;
`endif
         end
`ifdef LOADER_CSUM_EN
         CSUM: begin
            if (xfer) state_nxt = (strm.i_data == csum) ? RUN : ERR;
         end
`endif
         RUN, ERR: begin
            if (i_start) state_nxt = HDR;
         end
         default: state_nxt = HDR;
      endcase
   end

   // Write pointer and captured program length.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         len    <= '0;
      end else if (xfer && state == HDR) begin
         wr_ptr <= '0;
         if (!hdr_bad) len <= strm.i_data[ADDRESS_WIDTH:0];
      end else if (xfer && state == LOAD && !last_word) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   // CPU reset and sticky error follow the next state so they switch on the
   // same edge as the state change; ERR is only left via i_start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpu_rst <= 1'b1;
         o_err   <= 1'b0;
      end else begin
         cpu_rst <= (state_nxt != RUN);
         o_err   <= (state_nxt == ERR);
      end
   end

   // RAM port mux: CPU owns the port in RUN, loader writes during transfers.
   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      if (state == RUN) begin
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
         ram_we    = cpu_we;
      end else if (state == LOAD && strm.i_valid) begin
         ram_addr  = wr_ptr;
         ram_wdata = strm.i_data;
         ram_we    = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_prog_loader
//  Purpose  : Directed self-checking bench for fb_prog_loader. Expected RAM
//             writes are queued when stimulus is driven and popped when the
//             DUT asserts ram_we.
//  Option   : LOADER_CSUM_EN - adds checksum words and the checksum scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fb_prog_loader;
   localparam int AW = 6;
   localparam int DW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic          cpu_rst;
   logic          o_done;
   logic          o_err;

   int checks   = 0;
   int failures = 0;

   logic [AW+DW-1:0] exp_q[$];
   logic [DW-1:0]    mem[64];
   logic [DW-1:0]    prog[4];

   fb_prog_loader_if #(.DATA_WIDTH(DW)) strm ();

   fb_prog_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .strm      (strm),
      .i_start   (i_start),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_we    (cpu_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .cpu_rst   (cpu_rst),
      .o_done    (o_done),
      .o_err     (o_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: RAM writes are checked against the scoreboard mid-cycle,
   // then inputs may change 1 time unit after the rising edge.
   task automatic step();
      logic [AW+DW-1:0] e;
      @(negedge clk);
      if (ram_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ram_we", 32'(ram_addr), 32'hFFFF);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(ram_addr), 32'(e[AW+DW-1:DW]));
            check("wr_data", 32'(ram_wdata), 32'(e[DW-1:0]));
         end
         mem[ram_addr] = ram_wdata;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input int gap);
      strm.i_valid = 1'b1;
      strm.i_data  = d;
      step();
      strm.i_valid = 1'b0;
      strm.i_data  = '0;
      for (int g = 0; g < gap; g++) begin
         check("gap_cpu_rst", 32'(cpu_rst), 32'd1);
         step();
      end
   endtask

   // Full program load of prog[0..3]; checks the hand-over to the CPU.
   task automatic load_prog(input int gap);
      logic [DW-1:0] sum;
      sum = '0;
      send(10'h004, gap);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({AW'(i), prog[i]});
         sum = sum + prog[i];
         check("pre_run_cpu_rst", 32'(cpu_rst), 32'd1);
`ifdef LOADER_CSUM_EN
         send(prog[i], gap);
`else
         send(prog[i], (i == 3) ? 0 : gap);
`endif
      end
`ifdef LOADER_CSUM_EN
      send(sum, 0);
`endif
      check("run_cpu_rst", 32'(cpu_rst), 32'd0);
      check("run_done", 32'(o_done), 32'd1);
      check("run_ready", 32'(strm.o_ready), 32'd0);
      check("run_err", 32'(o_err), 32'd0);
   endtask

   task automatic check_mem();
      for (int i = 0; i < 4; i++) check($sformatf("mem%0d", i), 32'(mem[i]), 32'(prog[i]));
   endtask

   initial begin
      prog[0] = 10'h032; prog[1] = 10'h0B3; prog[2] = 10'h074; prog[3] = 10'h240;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      rst = 1'b0; i_start = 1'b0; strm.i_valid = 1'b0; strm.i_data = '0;
      cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      check("rst_ready", 32'(strm.o_ready), 32'd1);
      check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_err", 32'(o_err), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      rst = 1'b1;
      step();

      // Back-to-back load
      load_prog(0);
      check_mem();

      // CPU pass-through in RUN
      cpu_addr = 6'd52; cpu_wdata = 10'h00F; cpu_we = 1'b1;
      #1;
      check("pt_addr", 32'(ram_addr), 32'd52);
      check("pt_wdata", 32'(ram_wdata), 32'h00F);
      check("pt_we", 32'(ram_we), 32'd1);
      exp_q.push_back({6'd52, 10'h00F});
      step();
      check("mem52", 32'(mem[52]), 32'h00F);
      // i_start and i_valid together in RUN: restart wins, nothing consumed
      cpu_we = 1'b0; i_start = 1'b1; strm.i_valid = 1'b1; strm.i_data = 10'h003;
      step();
      i_start = 1'b0; strm.i_valid = 1'b0; strm.i_data = '0;
      check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
      check("restart_done", 32'(o_done), 32'd0);
      check("restart_ready", 32'(strm.o_ready), 32'd1);
      check("restart_ram_we", 32'(ram_we), 32'd0);

      // Bad headers: zero and DEPTH+1
      send(10'h000, 0);
      check("hdr0_err", 32'(o_err), 32'd1);
      check("hdr0_ready", 32'(strm.o_ready), 32'd0);
      check("hdr0_cpu_rst", 32'(cpu_rst), 32'd1);
      i_start = 1'b1; step(); i_start = 1'b0;
      check("clr0_err", 32'(o_err), 32'd0);
      check("clr0_ready", 32'(strm.o_ready), 32'd1);
      send(10'h041, 0);
      check("hdr65_err", 32'(o_err), 32'd1);
      check("hdr65_ready", 32'(strm.o_ready), 32'd0);
      check("hdr65_done", 32'(o_done), 32'd0);
      i_start = 1'b1; step(); i_start = 1'b0;
      check("clr65_err", 32'(o_err), 32'd0);
      // i_start in HDR is ignored
      i_start = 1'b1; step(); i_start = 1'b0;
      check("hdr_start_ready", 32'(strm.o_ready), 32'd1);

      // Load with 3-cycle gaps
      for (int i = 0; i < 4; i++) mem[i] = '0;
      load_prog(3);
      check_mem();
      i_start = 1'b1; step(); i_start = 1'b0;

      // Asynchronous reset mid-load
      send(10'h004, 0);
      exp_q.push_back({6'd0, prog[0]}); send(prog[0], 0);
      exp_q.push_back({6'd1, prog[1]}); send(prog[1], 0);
      #2;
      rst = 1'b0;
      #1;
      check("arst_ready", 32'(strm.o_ready), 32'd1);
      check("arst_cpu_rst", 32'(cpu_rst), 32'd1);
      check("arst_done", 32'(o_done), 32'd0);
      check("arst_err", 32'(o_err), 32'd0);
      check("arst_ram_we", 32'(ram_we), 32'd0);
      step();
      rst = 1'b1;
      load_prog(0);
      check_mem();

`ifdef LOADER_CSUM_EN
      // Checksum good then bad
      i_start = 1'b1; step(); i_start = 1'b0;
      send(10'h002, 0);
      exp_q.push_back({6'd0, 10'h005}); send(10'h005, 0);
      exp_q.push_back({6'd1, 10'h00A}); send(10'h00A, 0);
      check("csum_wait_cpu_rst", 32'(cpu_rst), 32'd1);
      send(10'h00F, 0);
      check("csum_ok_done", 32'(o_done), 32'd1);
      check("csum_ok_cpu_rst", 32'(cpu_rst), 32'd0);
      i_start = 1'b1; step(); i_start = 1'b0;
      send(10'h002, 0);
      exp_q.push_back({6'd0, 10'h005}); send(10'h005, 0);
      exp_q.push_back({6'd1, 10'h00A}); send(10'h00A, 0);
      send(10'h010, 0);
      check("csum_bad_err", 32'(o_err), 32'd1);
      check("csum_bad_cpu_rst", 32'(cpu_rst), 32'd1);
      check("csum_bad_done", 32'(o_done), 32'd0);
`endif

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
